pw_trigger_pulse_gen: RTL and testbench
=======================================

Name: pw_trigger_pulse_gen

Overview:
- Trigger-side consumer of the pattern matcher's single-cycle match-trigger strobe.
- On an armed match it waits a programmable delay, then drives a programmable train of trigger pulses (width, gap, count) on the physical trigger output.
- Reports busy/done/pulse-count status to the register block.
- One-shot per arm: re-arming requires I_arm to fall and rise again.

Parameters:
- pDELAY_WIDTH, 20, width of the delay counter and I_delay (cycles from match to first pulse).
- pPULSE_WIDTH, 17, width of the width and gap counters, I_width and I_gap.
- pCOUNT_WIDTH, 8, width of I_num_pulses and O_pulse_count.

Ports:
- trigger_clk  in  1  sole clock; all inputs synchronous to it.
- reset_i  in  1  asynchronous, active-high reset.
- I_arm  in  1  level arm from register block.
- I_match_trigger  in  1  single-cycle match strobe from pattern matcher.
- I_delay  in  pDELAY_WIDTH  cycles between match and first pulse.
- I_width  in  pPULSE_WIDTH  high time per pulse, in cycles.
- I_gap  in  pPULSE_WIDTH  low time between pulses, in cycles.
- I_num_pulses  in  pCOUNT_WIDTH  pulses per sequence.
- O_trigger  out  1  registered trigger output.
- O_busy  out  1  high from match acceptance until the sequence ends.
- O_done  out  1  one-cycle strobe at sequence completion.
- O_pulse_count  out  pCOUNT_WIDTH  pulses emitted in the current/last sequence.
- O_missed  out  8  saturating count of matches ignored while busy.

Behaviour:
- Interface (already decided): one clock, trigger_clk; reset_i is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, armed_ok = 0, prev_arm = 0.
- armed_ok:
  - Set on a rising edge of I_arm (I_arm & !prev_arm).
  - Cleared when a sequence completes or I_arm is low.
  - A level-high I_arm present out of reset does not arm; a rising edge is required.
- State IDLE:
  - Trigger condition: I_match_trigger & armed_ok.
  - On trigger, latch I_delay/I_width/I_gap/I_num_pulses into shadow registers, clear O_pulse_count, set O_busy next cycle.
  - Go to DELAY if delay > 0, else PULSE.
  - Later changes to config inputs do not affect the running sequence.
- Value clamping (applied at latch time):
  - width == 0 is treated as 1.
  - gap == 0 is treated as 1.
  - num_pulses == 0 is treated as 1.
- State DELAY: count delay cycles, then go to PULSE.
- Latency: O_trigger first rises exactly delay+1 cycles after the cycle in which I_match_trigger is sampled high (delay = 0 gives 1 cycle).
- State PULSE:
  - O_trigger = 1 for exactly width cycles.
  - O_pulse_count increments in the first cycle of each pulse.
  - On the last cycle: if pulses emitted < num_pulses, go to GAP; else go to DONE.
- State GAP: O_trigger = 0 for exactly gap cycles, then PULSE.
- State DONE (1 cycle):
  - O_trigger = 0, O_done = 1, O_busy = 0 from the next cycle.
  - Clear armed_ok and return to IDLE.
- Matches arriving outside IDLE:
  - Ignored; O_missed increments and saturates at 255.
  - O_missed clears on each I_arm rising edge.
- Match in the same cycle as the DONE state: ignored and counted as missed, because armed_ok is cleared by DONE.
- I_arm low mid-sequence:
  - Abort to IDLE next cycle: O_trigger 0, O_busy 0, no O_done.
  - O_pulse_count holds its value.
- I_arm rising edge coincident with I_match_trigger: not accepted, because armed_ok becomes 1 one cycle later.
- Async reset mid-sequence: O_trigger drops immediately (asynchronously), everything returns to reset values.
- Counters: down-counters loaded with value-1; no wrap is possible because the terminal count is detected at 0.

Decomposition:
- Shared package pw_trigger_pkg:
  - State encoding (IDLE, DELAY, PULSE, GAP, DONE).
  - Width localparams reused by the register block.
- Sub-module pw_down_counter (load/enable/terminal-count), instantiated for delay and for width/gap.
- FSM, arm-edge logic and status counters stay in the top module.

Test Plan:
- Arm rise, then match with delay=0, width=1, num=1 -> O_trigger high exactly 1 cycle, 1 cycle after match; O_done 1 cycle later; O_pulse_count=1.
- delay=10, width=3, gap=2, num=3 -> first rise 11 cycles after match; pattern 3 high / 2 low / 3 high / 2 low / 3 high; O_pulse_count=3; O_busy covers the whole span.
- Second match without re-arm after completion -> no O_trigger; toggle I_arm 0→1, then match -> sequence runs again.
- Two matches 5 cycles apart during a 20-cycle delay -> one sequence only; O_missed=1; I_arm re-rise clears O_missed to 0.
- Drop I_arm during pulse 2 of num=4 -> O_trigger 0 next cycle, O_busy 0, no O_done, O_pulse_count=2.
- Assert reset_i mid-PULSE between clock edges -> O_trigger 0 before the next edge; all outputs 0; a match after release with I_arm held high is ignored.

Source files
------------

// File: rtl/pw_trigger_pkg.sv
// -----------------------------------------------------------------------------
// pw_trigger_pkg
// Shared definitions for the trigger pulse generator and its register block:
// default field widths and the sequencer state encoding.
// -----------------------------------------------------------------------------
package pw_trigger_pkg;

  localparam int unsigned PW_DELAY_WIDTH  = 20;  // match-to-first-pulse delay
  localparam int unsigned PW_PULSE_WIDTH  = 17;  // pulse high / gap low time
  localparam int unsigned PW_COUNT_WIDTH  = 8;   // pulses per sequence
  localparam int unsigned PW_MISSED_WIDTH = 8;   // saturating missed-match count

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } pw_state_e;

endpackage

// File: rtl/pw_trigger_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// pw_trigger_pulse_gen_if
// Bundles the configuration, match strobe and status signals of the trigger
// pulse generator.
//   master : register block / pattern matcher side (drives I_*, reads O_*)
//   slave  : pulse generator side (reads I_*, drives O_*)
// Signals:
//   I_arm, I_match_trigger         arm level and single-cycle match strobe
//   I_delay, I_width, I_gap,
//   I_num_pulses                   sequence configuration
//   O_trigger, O_busy, O_done      trigger output and sequence status
//   O_pulse_count, O_missed        pulses emitted / matches ignored while busy
// -----------------------------------------------------------------------------
interface pw_trigger_pulse_gen_if
  import pw_trigger_pkg::*;
#(
  parameter int unsigned pDELAY_WIDTH = PW_DELAY_WIDTH,
  parameter int unsigned pPULSE_WIDTH = PW_PULSE_WIDTH,
  parameter int unsigned pCOUNT_WIDTH = PW_COUNT_WIDTH
);

  logic                       I_arm;
  logic                       I_match_trigger;
  logic [pDELAY_WIDTH-1:0]    I_delay;
  logic [pPULSE_WIDTH-1:0]    I_width;
  logic [pPULSE_WIDTH-1:0]    I_gap;
  logic [pCOUNT_WIDTH-1:0]    I_num_pulses;
  logic                       O_trigger;
  logic                       O_busy;
  logic                       O_done;
  logic [pCOUNT_WIDTH-1:0]    O_pulse_count;
  logic [PW_MISSED_WIDTH-1:0] O_missed;

  modport master (
    output I_arm, I_match_trigger, I_delay, I_width, I_gap, I_num_pulses,
    input  O_trigger, O_busy, O_done, O_pulse_count, O_missed
  );

  modport slave (
    input  I_arm, I_match_trigger, I_delay, I_width, I_gap, I_num_pulses,
    output O_trigger, O_busy, O_done, O_pulse_count, O_missed
  );

endinterface

// File: rtl/pw_down_counter.sv
// -----------------------------------------------------------------------------
// pw_down_counter
// Loadable down-counter that stops at zero. Callers load (cycles - 1) so the
// terminal count flags the last cycle of an interval.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         load load_val_i (has priority over en_i)
//   load_val_i     value to load
//   en_i           decrement while nonzero
//   tc_o           count is zero
// -----------------------------------------------------------------------------
module pw_down_counter #(
  parameter int unsigned pWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [pWIDTH-1:0] load_val_i,
  input  logic              en_i,
  output logic              tc_o
);

  localparam logic [pWIDTH-1:0] ONE = {{(pWIDTH-1){1'b0}}, 1'b1};

  logic [pWIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/pw_trigger_pulse_gen.sv
// -----------------------------------------------------------------------------
// pw_trigger_pulse_gen
// On an armed match strobe, waits I_delay cycles and then emits I_num_pulses
// pulses of I_width high / I_gap low cycles on O_trigger. One sequence per
// rising edge of I_arm; dropping I_arm aborts a running sequence.
//   trigger_clk  sole clock
//   reset_i      asynchronous active-high reset
//   bus          pw_trigger_pulse_gen_if.slave (config, strobe, status)
// -----------------------------------------------------------------------------
module pw_trigger_pulse_gen
  import pw_trigger_pkg::*;
#(
  parameter int unsigned pDELAY_WIDTH = PW_DELAY_WIDTH,
  parameter int unsigned pPULSE_WIDTH = PW_PULSE_WIDTH,
  parameter int unsigned pCOUNT_WIDTH = PW_COUNT_WIDTH
) (
  input logic                   trigger_clk,
  input logic                   reset_i,
  pw_trigger_pulse_gen_if.slave bus
);

  localparam logic [pPULSE_WIDTH-1:0] PW_ONE  = {{(pPULSE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pDELAY_WIDTH-1:0] DLY_ONE = {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};

  pw_state_e                  state_q;
  logic                       trigger_q, busy_q, done_q;
  logic                       armed_ok_q, prev_arm_q, seen_clk_q, pulse_first_q;
  logic [pCOUNT_WIDTH-1:0]    pcount_q, num_q;
  logic [PW_MISSED_WIDTH-1:0] missed_q;
  logic [pPULSE_WIDTH-1:0]    width_m1_q, gap_m1_q;

  logic                       arm_rise, start, abort, more_pulses;
  logic [pCOUNT_WIDTH-1:0]    emitted, num_in;
  logic [pPULSE_WIDTH-1:0]    width_in_m1, gap_in_m1;
  logic                       dly_load, dly_en, dly_tc;
  logic [pDELAY_WIDTH-1:0]    dly_load_val;
  logic                       pw_load, pw_en, pw_tc;
  logic [pPULSE_WIDTH-1:0]    pw_load_val;

  // seen_clk_q is low only on the first edge after reset, so an I_arm that is
  // already high when reset releases is not mistaken for a rising edge.
  assign arm_rise = bus.I_arm & ~prev_arm_q & seen_clk_q;
  assign start    = (state_q == ST_IDLE) & bus.I_match_trigger & armed_ok_q & bus.I_arm;
  assign abort    = (state_q != ST_IDLE) & ~bus.I_arm;

  // Zero width/gap/count behave as one; width/gap are kept as (value - 1).
  assign width_in_m1 = (bus.I_width == '0) ? '0 : bus.I_width - PW_ONE;
  assign gap_in_m1   = (bus.I_gap == '0) ? '0 : bus.I_gap - PW_ONE;
  assign num_in      = (bus.I_num_pulses == '0) ? CNT_ONE : bus.I_num_pulses;

  // Pulses emitted including the current one; the count register only catches
  // up at the end of a pulse's first cycle.
  assign emitted     = pcount_q + {{(pCOUNT_WIDTH-1){1'b0}}, pulse_first_q};
  assign more_pulses = (emitted < num_q);

  always_comb begin
    dly_load     = start && (bus.I_delay != '0);
    dly_load_val = bus.I_delay - DLY_ONE;
    dly_en       = (state_q == ST_DELAY) && !dly_tc;

    pw_load     = 1'b0;
    pw_load_val = '0;
    if (start && (bus.I_delay == '0)) begin
      pw_load     = 1'b1;
      pw_load_val = width_in_m1;
    end else if (((state_q == ST_DELAY) && dly_tc) || ((state_q == ST_GAP) && pw_tc)) begin
      pw_load     = 1'b1;
      pw_load_val = width_m1_q;
    end else if ((state_q == ST_PULSE) && pw_tc && more_pulses) begin
      pw_load     = 1'b1;
      pw_load_val = gap_m1_q;
    end
    pw_en = ((state_q == ST_PULSE) || (state_q == ST_GAP)) && !pw_tc;
  end

  pw_down_counter #(.pWIDTH(pDELAY_WIDTH)) u_delay_cnt (
    .clk_i      (trigger_clk),
    .rst_i      (reset_i),
    .load_i     (dly_load),
    .load_val_i (dly_load_val),
    .en_i       (dly_en),
    .tc_o       (dly_tc)
  );

  // Shared by pulse-high and gap intervals; they never overlap.
  pw_down_counter #(.pWIDTH(pPULSE_WIDTH)) u_pulse_cnt (
    .clk_i      (trigger_clk),
    .rst_i      (reset_i),
    .load_i     (pw_load),
    .load_val_i (pw_load_val),
    .en_i       (pw_en),
    .tc_o       (pw_tc)
  );

  // O_trigger is registered from the state, so it lags PULSE/GAP by one cycle;
  // this is what gives the delay+1 latency from match to first rise.
  always_ff @(posedge trigger_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      trigger_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      armed_ok_q    <= 1'b0;
      prev_arm_q    <= 1'b0;
      seen_clk_q    <= 1'b0;
      pulse_first_q <= 1'b0;
      pcount_q      <= '0;
      num_q         <= '0;
      missed_q      <= '0;
      width_m1_q    <= '0;
      gap_m1_q      <= '0;
    end else begin
      prev_arm_q <= bus.I_arm;
      seen_clk_q <= 1'b1;
      done_q     <= 1'b0;

      if (arm_rise) begin
        missed_q <= '0;
      end else if (bus.I_match_trigger && (state_q != ST_IDLE) && (missed_q != '1)) begin
        missed_q <= missed_q + 8'd1;
      end

      if (!bus.I_arm) begin
        armed_ok_q <= 1'b0;
      end else if (arm_rise) begin
        armed_ok_q <= 1'b1;
      end

      if (abort) begin
        state_q   <= ST_IDLE;
        trigger_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            trigger_q <= 1'b0;
            if (start) begin
              width_m1_q    <= width_in_m1;
              gap_m1_q      <= gap_in_m1;
              num_q         <= num_in;
              pcount_q      <= '0;
              busy_q        <= 1'b1;
              pulse_first_q <= 1'b1;
              state_q       <= (bus.I_delay == '0) ? ST_PULSE : ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (dly_tc) begin
              state_q       <= ST_PULSE;
              pulse_first_q <= 1'b1;
            end
          end
          ST_PULSE: begin
            trigger_q     <= 1'b1;
            pulse_first_q <= 1'b0;
            if (pulse_first_q) pcount_q <= emitted;
            if (pw_tc) state_q <= more_pulses ? ST_GAP : ST_DONE;
          end
          ST_GAP: begin
            trigger_q <= 1'b0;
            if (pw_tc) begin
              state_q       <= ST_PULSE;
              pulse_first_q <= 1'b1;
            end
          end
          ST_DONE: begin
            trigger_q  <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            armed_ok_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.O_trigger     = trigger_q;
  assign bus.O_busy        = busy_q;
  assign bus.O_done        = done_q;
  assign bus.O_pulse_count = pcount_q;
  assign bus.O_missed      = missed_q;

endmodule

// File: tb/tb_pw_trigger_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_pw_trigger_pulse_gen
// Self-checking bench: table of single-sequence vectors, hand-written corner
// sequences, then randomized traffic against a timeline reference model.
// -----------------------------------------------------------------------------
module tb_pw_trigger_pulse_gen;
  import pw_trigger_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pw_trigger_pulse_gen_if #(
    .pDELAY_WIDTH(PW_DELAY_WIDTH),
    .pPULSE_WIDTH(PW_PULSE_WIDTH),
    .pCOUNT_WIDTH(PW_COUNT_WIDTH)
  ) bus_if ();

  pw_trigger_pulse_gen #(
    .pDELAY_WIDTH(PW_DELAY_WIDTH),
    .pPULSE_WIDTH(PW_PULSE_WIDTH),
    .pCOUNT_WIDTH(PW_COUNT_WIDTH)
  ) dut (
    .trigger_clk (clk),
    .reset_i     (rst),
    .bus         (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d, w, g, n;          // configuration
    int first, highs, done_k, cnt;  // expected: first rise offset, high cycles, done offset, count
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int w, input int g, input int n);
    bus_if.I_delay      = 20'(d);
    bus_if.I_width      = 17'(w);
    bus_if.I_gap        = 17'(g);
    bus_if.I_num_pulses = 8'(n);
  endtask

  task automatic rearm();
    bus_if.I_arm = 1'b0;
    tick();
    bus_if.I_arm = 1'b1;
    tick();
  endtask

  // Issues one match (assumed armed) and observes 80 cycles. Offsets k count
  // samples after the accepting edge (k = 0 is the first sample after it).
  task automatic run_seq(input int d, input int w, input int g, input int n,
                         input int extra_k, input int abort_k,
                         output int first, output int highs, output int busy_n,
                         output int done_k, output int done_n, output int cnt0,
                         output int cnt, output int ab_trig, output int ab_busy);
    set_cfg(d, w, g, n);
    bus_if.I_match_trigger = 1'b1;
    tick();
    bus_if.I_match_trigger = 1'b0;
    // Config changes after acceptance must not disturb the running sequence.
    set_cfg($urandom_range(30, 60), $urandom_range(5, 9), $urandom_range(5, 9), $urandom_range(5, 9));
    first = -1; highs = 0; busy_n = 0; done_k = -1; done_n = 0;
    ab_trig = -1; ab_busy = -1;
    cnt0 = int'(bus_if.O_pulse_count);
    for (int k = 0; k < 80; k++) begin
      if (k == abort_k + 1) begin
        ab_trig = int'(bus_if.O_trigger);
        ab_busy = int'(bus_if.O_busy);
      end
      if (bus_if.O_trigger && first < 0) first = k;
      highs  += int'(bus_if.O_trigger);
      busy_n += int'(bus_if.O_busy);
      if (bus_if.O_done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      bus_if.I_match_trigger = (k == extra_k);
      if (k == abort_k) bus_if.I_arm = 1'b0;
      tick();
    end
    bus_if.I_match_trigger = 1'b0;
    cnt = int'(bus_if.O_pulse_count);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a sequence accepted at offset 0 is described purely by
  // arithmetic on the offset k: pulses start at d+1 + j*(w+g), the span ends
  // after n*(w+g)-g trigger cycles, and done appears right after the span.
  // ---------------------------------------------------------------------------
  bit m_active, m_armed, m_prev, m_seen, m_trig, m_busy, m_done;
  int m_k, m_d, m_w, m_g, m_n, m_count, m_missed;

  task automatic model_reset();
    m_active = 0; m_armed = 0; m_prev = 0; m_seen = 0;
    m_trig = 0; m_busy = 0; m_done = 0;
    m_k = 0; m_d = 0; m_w = 1; m_g = 1; m_n = 1; m_count = 0; m_missed = 0;
  endtask

  task automatic model_step(input bit a, input bit m, input int d, input int w, input int g, input int n);
    bit rise, was_active, completed;
    int per, span, off;
    rise = a && !m_prev && m_seen;
    was_active = m_active;
    completed = 0;
    m_done = 0;
    if (m_active) begin
      if (!a) begin
        m_active = 0; m_trig = 0; m_busy = 0;
      end else begin
        m_k++;
        per  = m_w + m_g;
        span = m_n * per - m_g;
        if (m_k == m_d + 1 + span) begin
          m_active = 0; completed = 1;
          m_trig = 0; m_busy = 0; m_done = 1; m_count = m_n;
        end else begin
          m_busy = 1;
          if (m_k >= m_d + 1) begin
            off = m_k - m_d - 1;
            m_trig = ((off % per) < m_w);
            m_count = (off / per + 1 < m_n) ? off / per + 1 : m_n;
          end else begin
            m_trig = 0;
          end
        end
      end
    end else begin
      m_trig = 0; m_busy = 0;
      if (m && a && m_armed) begin
        m_active = 1; m_k = 0; m_busy = 1; m_count = 0;
        m_d = d;
        m_w = (w == 0) ? 1 : w;
        m_g = (g == 0) ? 1 : g;
        m_n = (n == 0) ? 1 : n;
      end
    end
    if (!a) m_armed = 0;
    else if (rise) m_armed = 1;
    else if (completed) m_armed = 0;
    if (rise) m_missed = 0;
    else if (m && was_active && m_missed < 255) m_missed++;
    m_prev = a;
    m_seen = 1;
  endtask

  initial begin
    int first, highs, busy_n, done_k, done_n, cnt0, cnt, ab_trig, ab_busy;
    int seen_hi, seen_busy;

    vecs[0] = '{d: 0,  w: 1, g: 1, n: 1, first: 1,  highs: 1, done_k: 2,  cnt: 1};
    vecs[1] = '{d: 10, w: 3, g: 2, n: 3, first: 11, highs: 9, done_k: 24, cnt: 3};
    vecs[2] = '{d: 0,  w: 0, g: 0, n: 0, first: 1,  highs: 1, done_k: 2,  cnt: 1};
    vecs[3] = '{d: 2,  w: 2, g: 0, n: 2, first: 3,  highs: 4, done_k: 8,  cnt: 2};
    vecs[4] = '{d: 1,  w: 1, g: 3, n: 3, first: 2,  highs: 3, done_k: 11, cnt: 3};
    vecs[5] = '{d: 0,  w: 5, g: 1, n: 1, first: 1,  highs: 5, done_k: 6,  cnt: 1};

    bus_if.I_arm = 1'b0;
    bus_if.I_match_trigger = 1'b0;
    set_cfg(0, 1, 1, 1);

    // Reset state
    tick(); tick();
    check("reset_trigger", 32'(bus_if.O_trigger), 0);
    check("reset_busy", 32'(bus_if.O_busy), 0);
    check("reset_done", 32'(bus_if.O_done), 0);
    check("reset_count", 32'(bus_if.O_pulse_count), 0);
    check("reset_missed", 32'(bus_if.O_missed), 0);
    rst = 1'b0;
    tick();

    // Table of single sequences
    foreach (vecs[i]) begin
      rearm();
      run_seq(vecs[i].d, vecs[i].w, vecs[i].g, vecs[i].n, -1, -1,
              first, highs, busy_n, done_k, done_n, cnt0, cnt, ab_trig, ab_busy);
      check($sformatf("v%0d_first_rise", i), first, vecs[i].first);
      check($sformatf("v%0d_high_cycles", i), highs, vecs[i].highs);
      check($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].done_k);
      check($sformatf("v%0d_done_offset", i), done_k, vecs[i].done_k);
      check($sformatf("v%0d_done_width", i), done_n, 1);
      check($sformatf("v%0d_count_cleared", i), cnt0, 0);
      check($sformatf("v%0d_pulse_count", i), cnt, vecs[i].cnt);
    end

    // No re-arm after completion: match ignored and not counted as missed
    bus_if.I_match_trigger = 1'b1;
    tick();
    bus_if.I_match_trigger = 1'b0;
    seen_hi = 0; seen_busy = 0;
    for (int k = 0; k < 30; k++) begin
      seen_hi += int'(bus_if.O_trigger);
      seen_busy += int'(bus_if.O_busy);
      tick();
    end
    check("norearm_trigger", seen_hi, 0);
    check("norearm_busy", seen_busy, 0);
    check("norearm_missed", 32'(bus_if.O_missed), 0);
    rearm();
    run_seq(0, 1, 1, 1, -1, -1, first, highs, busy_n, done_k, done_n, cnt0, cnt, ab_trig, ab_busy);
    check("rearm_first_rise", first, 1);
    check("rearm_done_offset", done_k, 2);

    // Second match 5 cycles into a 20-cycle delay
    rearm();
    run_seq(20, 2, 1, 2, 4, -1, first, highs, busy_n, done_k, done_n, cnt0, cnt, ab_trig, ab_busy);
    check("dbl_first_rise", first, 21);
    check("dbl_high_cycles", highs, 4);
    check("dbl_done_count", done_n, 1);
    check("dbl_missed", 32'(bus_if.O_missed), 1);
    rearm();
    check("dbl_missed_cleared", 32'(bus_if.O_missed), 0);

    // Drop I_arm in the first high cycle of pulse 2 (num=4)
    run_seq(0, 3, 2, 4, -1, 6, first, highs, busy_n, done_k, done_n, cnt0, cnt, ab_trig, ab_busy);
    check("abort_trigger", ab_trig, 0);
    check("abort_busy", ab_busy, 0);
    check("abort_no_done", done_n, 0);
    check("abort_count", cnt, 2);
    check("abort_high_cycles", highs, 4);

    // Arm rise coincident with match is not accepted
    bus_if.I_arm = 1'b0;
    tick();
    bus_if.I_arm = 1'b1;
    bus_if.I_match_trigger = 1'b1;
    tick();
    bus_if.I_match_trigger = 1'b0;
    seen_busy = 0;
    for (int k = 0; k < 10; k++) begin
      seen_busy += int'(bus_if.O_busy) + int'(bus_if.O_trigger);
      tick();
    end
    check("coincident_ignored", seen_busy, 0);
    run_seq(3, 1, 1, 1, -1, -1, first, highs, busy_n, done_k, done_n, cnt0, cnt, ab_trig, ab_busy);
    check("coincident_then_armed", first, 4);

    // Asynchronous reset mid-pulse
    rearm();
    set_cfg(0, 20, 1, 1);
    bus_if.I_match_trigger = 1'b1;
    tick();
    bus_if.I_match_trigger = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("pre_reset_trigger", 32'(bus_if.O_trigger), 1);
    #3 rst = 1'b1;
    #1;
    check("async_reset_trigger", 32'(bus_if.O_trigger), 0);
    check("async_reset_busy", 32'(bus_if.O_busy), 0);
    check("async_reset_count", 32'(bus_if.O_pulse_count), 0);
    tick();
    rst = 1'b0;
    tick();
    bus_if.I_match_trigger = 1'b1;
    tick();
    bus_if.I_match_trigger = 1'b0;
    seen_busy = 0;
    for (int k = 0; k < 20; k++) begin
      seen_busy += int'(bus_if.O_busy) + int'(bus_if.O_trigger);
      tick();
    end
    check("post_reset_level_arm_ignored", seen_busy, 0);

    // Randomized traffic against the reference model
    rst = 1'b1;
    bus_if.I_arm = 1'b0;
    bus_if.I_match_trigger = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bit a, m;
      int d, w, g, n;
      a = ($urandom_range(0, 99) < 94);
      m = ($urandom_range(0, 99) < 20);
      d = $urandom_range(0, 6);
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 3);
      n = $urandom_range(0, 4);
      bus_if.I_arm = a;
      bus_if.I_match_trigger = m;
      set_cfg(d, w, g, n);
      tick();
      model_step(a, m, d, w, g, n);
      check($sformatf("rnd%0d_trigger", c), 32'(bus_if.O_trigger), 32'(m_trig));
      check($sformatf("rnd%0d_busy", c), 32'(bus_if.O_busy), 32'(m_busy));
      check($sformatf("rnd%0d_done", c), 32'(bus_if.O_done), 32'(m_done));
      check($sformatf("rnd%0d_count", c), 32'(bus_if.O_pulse_count), m_count);
      check($sformatf("rnd%0d_missed", c), 32'(bus_if.O_missed), m_missed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
